alarm_ringer: RTL and testbench
===============================

ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
- REQ-001 SHALL have parameter RING_SEC, default 60: ring duration in _1Hz cycles, 1..1023.
- REQ-002 SHALL have parameter SNOOZE_SEC, default 300: snooze duration in _1Hz cycles, 1..1023.
- REQ-003 SHALL have parameter SNOOZE_MAX, default 3: maximum snoozes per alarm event, 0..3.
- REQ-004 SHALL have port _1Hz, input, 1 bit: the single clock, rising-edge active.
- REQ-005 SHALL have port nCR, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 SHALL have port ALARM_Clock, input, 1 bit: time-match level from the alarm comparator, synchronous to _1Hz.
- REQ-007 SHALL have port AlarmEn, input, 1 bit: alarm arm switch (1 = armed).
- REQ-008 SHALL have port StopKey, input, 1 bit: stop key level, synchronous.
- REQ-009 SHALL have port SnoozeKey, input, 1 bit: snooze key level, synchronous.
- REQ-010 SHALL have port Buzz, output, 1 bit: buzzer gate to the tone generator.
- REQ-011 SHALL have port Ringing, output, 1 bit: high while in RING.
- REQ-012 SHALL have port Snoozing, output, 1 bit: high while in SNOOZE.
- REQ-013 SHALL have port SnoozeCnt, output, 2 bits: snoozes used in the current alarm event.

Function
- REQ-014 SHALL implement states IDLE, RING and SNOOZE, with all outputs registered.
- REQ-015 SHALL register ALARM_Clock, StopKey and SnoozeKey once each; an event is a sample of 1 whose previous registered sample is 0; a held input SHALL produce one event only.
- REQ-016 IDLE->RING SHALL occur on the edge where AlarmEn=1 and an ALARM_Clock event is detected; Ringing SHALL be high after that same edge.
- REQ-017 A RING timer SHALL clear on entry to RING and increment each cycle in RING; on the edge where it equals RING_SEC-1, RING->IDLE, so Ringing is high for exactly RING_SEC cycles.
- REQ-018 In RING, a SnoozeKey event with SnoozeCnt<SNOOZE_MAX SHALL cause RING->SNOOZE, increment SnoozeCnt, and load the snooze timer with SNOOZE_SEC-1.
- REQ-019 In RING, a SnoozeKey event with SnoozeCnt=SNOOZE_MAX SHALL be ignored.
- REQ-020 In SNOOZE, the snooze timer SHALL decrement each cycle; on the edge where it equals 0, SNOOZE->RING with the RING timer cleared, so Snoozing is high for exactly SNOOZE_SEC cycles.
- REQ-021 A StopKey event in RING or SNOOZE SHALL cause a transition to IDLE.
- REQ-022 AlarmEn=0 SHALL force IDLE from any state on the next edge.
- REQ-023 Priority SHALL be, highest first: AlarmEn=0, StopKey event, SnoozeKey event, timer expiry.
- REQ-024 On every entry to IDLE, SnoozeCnt SHALL clear to 0.
- REQ-025 An ALARM_Clock event in RING or SNOOZE SHALL be ignored; ALARM_Clock still high on return to IDLE SHALL NOT re-trigger.
- REQ-026 Buzz SHALL be 0 outside RING.
- REQ-027 Timers SHALL be 10 bits wide and SHALL NOT wrap.

Reset
- REQ-028 nCR=0 SHALL asynchronously force state IDLE and Buzz=0, Ringing=0, Snoozing=0, SnoozeCnt=0.
- REQ-029 nCR=0 SHALL clear both timers and all input history registers to 0.
- REQ-030 Reset mid-RING or mid-SNOOZE SHALL abort the alarm event; after release, only a new ALARM_Clock event SHALL re-trigger.

Configuration
- REQ-031 Macro ALARM_BEEP_PATTERN_EN defined: in RING, Buzz SHALL be 1 on the first RING cycle and toggle every cycle (1 s on / 1 s off), restarting at 1 on each entry to RING.
- REQ-032 Macro ALARM_BEEP_PATTERN_EN undefined: Buzz SHALL equal Ringing (steady tone).

Verification
- REQ-033 Defaults, AlarmEn=1, ALARM_Clock 0->1 and held 60 cycles -> Ringing high exactly 60 cycles, then IDLE with no re-trigger.
- REQ-034 SnoozeKey pulse at RING cycle 5 -> Snoozing high 300 cycles, then Ringing with SnoozeCnt=1 and RING timer restarted.
- REQ-035 Three snoozes, then a fourth SnoozeKey in RING -> ignored, SnoozeCnt stays 3, Ringing continues until timeout.
- REQ-036 StopKey and SnoozeKey rising on the same cycle in RING -> IDLE, SnoozeCnt=0; StopKey held for 10 cycles acts once.
- REQ-037 nCR pulsed low mid-SNOOZE -> all outputs 0 immediately; AlarmEn dropped mid-RING -> IDLE next edge.
- REQ-038 With ALARM_BEEP_PATTERN_EN defined, Buzz in RING -> 1,0,1,0,...; with it undefined -> Buzz constant 1.

Source files
------------

// File: rtl/alarm_ringer.sv
// -----------------------------------------------------------------------------
// alarm_ringer
//   Alarm ringing controller clocked by the 1 Hz time base. Watches the alarm
//   comparator match level and the stop/snooze keys, and sequences the buzzer
//   through IDLE -> RING -> (SNOOZE -> RING)* -> IDLE.
//
//   Optional feature macro: ALARM_BEEP_PATTERN_EN
//     defined   : Buzz beeps 1 s on / 1 s off while ringing, starting with 1
//                 on every entry to RING.
//     undefined : Buzz follows Ringing (steady tone).
//
//   Handshake note: there is no valid/ready traffic here. All inputs are level
//   signals synchronous to _1Hz; an input "event" is the first cycle a level is
//   seen high after having been low on the previous registered sample. Every
//   output is a register updated on the rising edge of _1Hz.
//
//   Observability: the FSM state is fully visible on the Ringing / Snoozing
//   outputs (both low = IDLE), which are registered copies of the state.
// -----------------------------------------------------------------------------
module alarm_ringer #(
   parameter int unsigned RING_SEC   = 60,   // ring duration in cycles, 1..1023
   parameter int unsigned SNOOZE_SEC = 300,  // snooze duration in cycles, 1..1023
   parameter int unsigned SNOOZE_MAX = 3     // snoozes allowed per alarm event, 0..3
) (
   input  logic       _1Hz,
   input  logic       nCR,
   input  logic       ALARM_Clock,
   input  logic       AlarmEn,
   input  logic       StopKey,
   input  logic       SnoozeKey,
   output logic       Buzz,
   output logic       Ringing,
   output logic       Snoozing,
   output logic [1:0] SnoozeCnt
);

   // Timer constants, truncated to the 10-bit timer width.
   localparam logic [9:0] RING_LAST   = 10'(RING_SEC - 1);
   localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC - 1);
   localparam logic [9:0] TMR_MAX     = 10'h3FF;
   localparam logic [1:0] SNOOZE_LIM  = 2'(SNOOZE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_e;

   state_e     state_q, state_d;

   // Input history: previous registered sample of each level input.
   logic       alarm_hist_q;
   logic       stop_hist_q;
   logic       snooze_hist_q;

   // Timers: ring counts up from 0, snooze counts down to 0.
   logic [9:0] ring_tmr_q, ring_tmr_d;
   logic [9:0] snz_tmr_q,  snz_tmr_d;

   // Registered outputs.
   logic [1:0] cnt_q,      cnt_d;
   logic       buzz_q,     buzz_d;
   logic       ringing_q,  ringing_d;
   logic       snoozing_q, snoozing_d;

   // Event detection and timer status.
   logic       alarm_ev;
   logic       stop_ev;
   logic       snooze_ev;
   logic       ring_done;
   logic       snz_done;
   logic       snooze_ok;

   assign alarm_ev  = ALARM_Clock & ~alarm_hist_q;
   assign stop_ev   = StopKey     & ~stop_hist_q;
   assign snooze_ev = SnoozeKey   & ~snooze_hist_q;
   assign ring_done = (ring_tmr_q == RING_LAST);
   assign snz_done  = (snz_tmr_q == 10'd0);
   assign snooze_ok = (cnt_q < SNOOZE_LIM);

   // Input history registers: one sample per input, cleared by reset.
   always_ff @(posedge _1Hz or negedge nCR) begin
      if (!nCR) begin
         alarm_hist_q  <= 1'b0;
         stop_hist_q   <= 1'b0;
         snooze_hist_q <= 1'b0;
      end else begin
         alarm_hist_q  <= ALARM_Clock;
         stop_hist_q   <= StopKey;
         snooze_hist_q <= SnoozeKey;
      end
   end

   // State register.
   always_ff @(posedge _1Hz or negedge nCR) begin
      if (!nCR) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; priority is disarm, stop, snooze, timer expiry.
   always_comb begin
      state_d = state_q;
      if (!AlarmEn) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (alarm_ev) begin
                  state_d = ST_RING;
               end
            end
            ST_RING: begin
               if (stop_ev) begin
                  state_d = ST_IDLE;
               end else if (snooze_ev && snooze_ok) begin
                  state_d = ST_SNOOZE;
               end else if (ring_done) begin
                  state_d = ST_IDLE;
               end
            end
            ST_SNOOZE: begin
               if (stop_ev) begin
                  state_d = ST_IDLE;
               end else if (snz_done) begin
                  state_d = ST_RING;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output and timer next values, derived from the current/next state pair.
   always_comb begin
      ring_tmr_d = 10'd0;
      snz_tmr_d  = 10'd0;
      cnt_d      = cnt_q;
      ringing_d  = (state_d == ST_RING);
      snoozing_d = (state_d == ST_SNOOZE);

      // Ring timer restarts on every entry to RING and saturates rather than wraps.
      if (state_d == ST_RING) begin
         if (state_q != ST_RING) begin
            ring_tmr_d = 10'd0;
         end else if (ring_tmr_q != TMR_MAX) begin
            ring_tmr_d = ring_tmr_q + 10'd1;
         end else begin
            ring_tmr_d = ring_tmr_q;
         end
      end

      // Snooze timer loads on entry to SNOOZE and stops at zero.
      if (state_d == ST_SNOOZE) begin
         if (state_q != ST_SNOOZE) begin
            snz_tmr_d = SNOOZE_LOAD;
         end else if (!snz_done) begin
            snz_tmr_d = snz_tmr_q - 10'd1;
         end else begin
            snz_tmr_d = snz_tmr_q;
         end
      end

      // Snooze count belongs to one alarm event: cleared whenever we land in IDLE.
      if (state_d == ST_IDLE) begin
         cnt_d = 2'd0;
      end else if ((state_q == ST_RING) && (state_d == ST_SNOOZE)) begin
         cnt_d = cnt_q + 2'd1;
      end

`ifdef ALARM_BEEP_PATTERN_EN
      // Beep: 1 on the first RING cycle, then alternate each cycle.
      buzz_d = (state_d == ST_RING) && ((state_q != ST_RING) || !buzz_q);
`else
      // Steady tone for as long as we ring.
      buzz_d = (state_d == ST_RING);
`endif
   end

   // Timer and output registers.
   always_ff @(posedge _1Hz or negedge nCR) begin
      if (!nCR) begin
         ring_tmr_q <= 10'd0;
         snz_tmr_q  <= 10'd0;
         cnt_q      <= 2'd0;
         buzz_q     <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         ring_tmr_q <= ring_tmr_d;
         snz_tmr_q  <= snz_tmr_d;
         cnt_q      <= cnt_d;
         buzz_q     <= buzz_d;
         ringing_q  <= ringing_d;
         snoozing_q <= snoozing_d;
      end
   end

   assign Buzz      = buzz_q;
   assign Ringing   = ringing_q;
   assign Snoozing  = snoozing_q;
   assign SnoozeCnt = cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// -----------------------------------------------------------------------------
// tb_alarm_ringer
//   Bench for alarm_ringer with default parameters. A driver applies one input
//   vector per cycle, steps a behavioural model (seconds-remaining counters and
//   a snooze tally) and pushes the expected outputs; a monitor pops them one
//   cycle at a time just after each rising edge and compares.
//   Build with ALARM_BEEP_PATTERN_EN defined to check the beep pattern.
// -----------------------------------------------------------------------------
module tb_alarm_ringer;

   localparam int RING_SEC   = 60;
   localparam int SNOOZE_SEC = 300;
   localparam int SNOOZE_MAX = 3;

`ifdef ALARM_BEEP_PATTERN_EN
   localparam bit BEEP_PATTERN = 1'b1;
`else
   localparam bit BEEP_PATTERN = 1'b0;
`endif

   localparam int M_IDLE   = 0;
   localparam int M_RING   = 1;
   localparam int M_SNOOZE = 2;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       n_cr;
   logic       alarm_clk;
   logic       alarm_en;
   logic       stop_key;
   logic       snooze_key;
   logic       buzz;
   logic       ringing;
   logic       snoozing;
   logic [1:0] snooze_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alarm_ringer #(
      .RING_SEC  (RING_SEC),
      .SNOOZE_SEC(SNOOZE_SEC),
      .SNOOZE_MAX(SNOOZE_MAX)
   ) dut (
      ._1Hz       (clk),
      .nCR        (n_cr),
      .ALARM_Clock(alarm_clk),
      .AlarmEn    (alarm_en),
      .StopKey    (stop_key),
      .SnoozeKey  (snooze_key),
      .Buzz       (buzz),
      .Ringing    (ringing),
      .Snoozing   (snoozing),
      .SnoozeCnt  (snooze_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [4:0] exp_q[$];   // {buzz, ringing, snoozing, snooze_cnt[1:0]}
   int         checks = 0;
   int         errors = 0;
   int         cycle  = 0;

   // ---------------- behavioural model ----------------
   int m_mode      = M_IDLE;
   int m_ring_left = 0;
   int m_snz_left  = 0;
   int m_snoozes   = 0;
   bit m_beep      = 1'b0;
   bit m_pa        = 1'b0;
   bit m_pst       = 1'b0;
   bit m_psn       = 1'b0;

   task automatic model_reset();
      m_mode      = M_IDLE;
      m_ring_left = 0;
      m_snz_left  = 0;
      m_snoozes   = 0;
      m_beep      = 1'b0;
      m_pa        = 1'b0;
      m_pst       = 1'b0;
      m_psn       = 1'b0;
   endtask

   task automatic go_idle();
      m_mode    = M_IDLE;
      m_snoozes = 0;
   endtask

   task automatic start_ring();
      m_mode      = M_RING;
      m_ring_left = RING_SEC;
      m_beep      = 1'b1;
   endtask

   // One clock edge of the alarm behaviour.
   task automatic model_step(input bit a, input bit en, input bit st, input bit sn);
      bit ev_a;
      bit ev_st;
      bit ev_sn;
      ev_a  = a  && !m_pa;
      ev_st = st && !m_pst;
      ev_sn = sn && !m_psn;
      m_pa  = a;
      m_pst = st;
      m_psn = sn;
      if (!en) begin
         go_idle();
      end else if (m_mode == M_IDLE) begin
         if (ev_a) start_ring();
      end else if (m_mode == M_RING) begin
         if (ev_st) begin
            go_idle();
         end else if (ev_sn && (m_snoozes < SNOOZE_MAX)) begin
            m_mode     = M_SNOOZE;
            m_snoozes  = m_snoozes + 1;
            m_snz_left = SNOOZE_SEC;
         end else begin
            m_ring_left = m_ring_left - 1;
            if (m_ring_left == 0) go_idle();
            else m_beep = !m_beep;
         end
      end else begin
         if (ev_st) begin
            go_idle();
         end else begin
            m_snz_left = m_snz_left - 1;
            if (m_snz_left == 0) start_ring();
         end
      end
   endtask

   function automatic logic [4:0] model_outputs();
      logic r;
      logic s;
      logic b;
      r = (m_mode == M_RING);
      s = (m_mode == M_SNOOZE);
      b = r && (BEEP_PATTERN ? m_beep : 1'b1);
      return {b, r, s, 2'(m_snoozes)};
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a falling edge; leaves at the next falling edge.
   task automatic drive_cycle(input bit a, input bit en, input bit st, input bit sn);
      alarm_clk  = a;
      alarm_en   = en;
      stop_key   = st;
      snooze_key = sn;
      model_step(a, en, st, sn);
      exp_q.push_back(model_outputs());
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit a, input bit en, input bit st, input bit sn);
      for (int i = 0; i < n; i++) drive_cycle(a, en, st, sn);
   endtask

   task automatic check_reset_now(input string name);
      checks++;
      if ({buzz, ringing, snoozing, snooze_cnt} !== 5'b0) begin
         errors++;
         $display("FAIL %s: got buzz/ring/snz/cnt=%b/%b/%b/%0d, expected all 0",
                  name, buzz, ringing, snoozing, snooze_cnt);
      end
   endtask

   // Asynchronous reset pulse placed between edges; outputs must clear at once.
   task automatic pulse_reset();
      #2;
      alarm_clk  = 1'b0;
      stop_key   = 1'b0;
      snooze_key = 1'b0;
      n_cr       = 1'b0;
      #1;
      check_reset_now("async_reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      n_cr = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      logic [4:0] exp_v;
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         checks++;
         if ({buzz, ringing, snoozing, snooze_cnt} !== exp_v) begin
            errors++;
            $display("FAIL outputs cycle %0d: got buzz/ring/snz/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                     cycle, buzz, ringing, snoozing, snooze_cnt,
                     exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit a_lvl;
      n_cr       = 1'b1;
      alarm_clk  = 1'b0;
      alarm_en   = 1'b1;
      stop_key   = 1'b0;
      snooze_key = 1'b0;
      #2;
      n_cr = 1'b0;
      #1;
      check_reset_now("power_on_reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      n_cr = 1'b1;

      // Held alarm match: one ring of RING_SEC cycles, no re-trigger.
      run(3, 0, 1, 0, 0);
      run(RING_SEC + 20, 1, 1, 0, 0);
      run(5, 0, 1, 0, 0);

      // Snooze at ring cycle 5, full snooze, back to ring, then stop.
      run(1, 1, 1, 0, 0);
      run(4, 0, 1, 0, 0);
      run(1, 0, 1, 0, 1);
      run(SNOOZE_SEC + 10, 0, 1, 0, 0);
      run(1, 0, 1, 1, 0);
      run(3, 0, 1, 0, 0);

      // Three snoozes, a fourth is ignored, ring runs to timeout.
      run(1, 1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         run(3, 0, 1, 0, 0);
         run(1, 0, 1, 0, 1);
         run(SNOOZE_SEC + 2, 0, 1, 0, 0);
      end
      run(1, 0, 1, 0, 1);
      run(RING_SEC + 5, 0, 1, 0, 0);

      // Stop and snooze together, stop held 10 cycles.
      run(1, 1, 1, 0, 0);
      run(3, 0, 1, 0, 0);
      run(10, 0, 1, 1, 1);
      run(3, 0, 1, 0, 0);
      run(1, 1, 1, 1, 0);
      run(5, 0, 1, 1, 0);
      run(3, 0, 1, 0, 0);

      // Reset in the middle of a snooze, then a fresh event.
      run(1, 1, 1, 0, 0);
      run(2, 0, 1, 0, 0);
      run(1, 0, 1, 0, 1);
      run(20, 0, 1, 0, 0);
      pulse_reset();
      run(5, 0, 1, 0, 0);
      run(1, 1, 1, 0, 0);
      run(6, 1, 1, 0, 0);

      // Disarm mid ring, then disarmed alarm match does nothing.
      run(1, 0, 0, 0, 0);
      run(3, 0, 1, 0, 0);
      run(4, 1, 0, 0, 0);
      run(4, 1, 1, 0, 0);
      run(2, 0, 1, 0, 0);

      // Randomised phase with occasional resets.
      a_lvl = 1'b0;
      for (int i = 0; i < 24000; i++) begin
         bit en;
         bit st;
         bit sn;
         if ($urandom_range(0, 59) == 0) a_lvl = !a_lvl;
         en = ($urandom_range(0, 399) != 0);
         st = ($urandom_range(0, 249) == 0);
         sn = ($urandom_range(0, 24) == 0);
         drive_cycle(a_lvl, en, st, sn);
         if ((i % 6000) == 5999) begin
            pulse_reset();
            a_lvl = 1'b0;
         end
      end
      run(2, 0, 1, 0, 0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
